rf_wport_arbiter: RTL and testbench

Round-robin arbiter sharing the single register-file write port, built from `dff` bit cells with per-bit write enable, among up to NREQ writers (ALU writeback, load unit, etc.). Samples requests each cycle, issues exactly one registered write per cycle to the register file, and returns a one-cycle grant pulse to the winner. Sits between the pipeline writeback sources and the register-file `wen`/address/data inputs.

---
 rtl/rf_wport_arbiter_pkg.sv | 18 +
 rtl/rf_wport_arbiter_rr_pick.sv | 39 +++
 rtl/rf_wport_arbiter.sv | 85 ++++++++
 tb/tb_rf_wport_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/rf_wport_arbiter_pkg.sv
// rf_wport_arbiter_pkg: shared defaults and state encoding for the register-file write-port arbiter
package rf_wport_arbiter_pkg;

    localparam int NREQ_DEF = 4;
    localparam int AW_DEF   = 3;
    localparam int DW_DEF   = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Pointer width; a 1-bit pointer is still needed when NREQ is small.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_wport_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority pick of the first eligible index at or after ptr
//   elig  in   NREQ  eligible requesters
//   ptr   in   PW    highest-priority index this cycle
//   win   out  NREQ  one-hot winner (zero when nothing eligible)
//   idx   out  PW    binary index of the winner
//   valid out  1     at least one requester eligible
module rr_pick
    import rf_wport_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int PW   = ptr_w(NREQ_DEF)
) (
    input  logic [NREQ-1:0] elig,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [PW-1:0]   idx,
    output logic            valid
);

    logic [PW-1:0] j;

    // Scan from the farthest offset down to offset 0 so the nearest
    // eligible index to ptr overwrites any earlier match.
    always_comb begin
        win   = '0;
        idx   = '0;
        j     = '0;
        valid = |elig;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = PW'((int'(ptr) + k) % NREQ);
            if (elig[j]) begin
                win    = '0;
                win[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: round-robin arbiter for the single register-file write port
//   clk       in   1        clock
//   rst       in   1        asynchronous active-low reset
//   req       in   NREQ     per-requester write request (level, held until granted)
//   req_addr  in   NREQ*AW  requester i address at [i*AW +: AW]
//   req_data  in   NREQ*DW  requester i data at [i*DW +: DW]
//   gnt       out  NREQ     one-hot one-cycle grant pulse
//   rf_wen    out  1        register-file write enable
//   rf_waddr  out  AW       register-file write address
//   rf_wdata  out  DW       register-file write data
// Optional: RF_WPORT_R0_GUARD_EN suppresses rf_wen for writes to register 0.
module rf_wport_arbiter
    import rf_wport_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic               rf_wen,
    output logic [AW-1:0]      rf_waddr,
    output logic [DW-1:0]      rf_wdata
);

    localparam int PW = ptr_w(NREQ);

    state_t          state, state_nx;
    logic [PW-1:0]   ptr, ptr_nx;
    logic [NREQ-1:0] gnt_nx;
    logic [AW-1:0]   waddr_nx;
    logic [DW-1:0]   wdata_nx;
    logic [NREQ-1:0] elig, win;
    logic [PW-1:0]   idx;
    logic            valid;

    // The current grantee is masked so a requester that drops req on the
    // edge after its grant is not granted a second time.
    assign elig = req & ~gnt;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .elig  (elig),
        .ptr   (ptr),
        .win   (win),
        .idx   (idx),
        .valid (valid)
    );

    always_comb begin
        state_nx = valid ? GRANT : IDLE;
        gnt_nx   = valid ? win : '0;
        waddr_nx = valid ? req_addr[idx*AW +: AW] : rf_waddr;
        wdata_nx = valid ? req_data[idx*DW +: DW] : rf_wdata;
        ptr_nx   = !valid ? ptr : (idx == PW'(NREQ - 1)) ? '0 : idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            gnt      <= '0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            gnt      <= gnt_nx;
            rf_waddr <= waddr_nx;
            rf_wdata <= wdata_nx;
        end
    end

    // Enable is decoded from registered state only, so no input reaches it
    // combinationally.
`ifdef RF_WPORT_R0_GUARD_EN
    assign rf_wen = (state == GRANT) && (rf_waddr != '0);
`else
    assign rf_wen = (state == GRANT);
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb_rf_wport_arbiter: table-driven scoreboard bench for rf_wport_arbiter
module tb_rf_wport_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 3;
    localparam int DW   = 16;
`ifdef RF_WPORT_R0_GUARD_EN
    localparam logic W1 = 1'b0;
`else
    localparam logic W1 = 1'b1;
`endif

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  gnt;
        logic        wen;
        logic [2:0]  addr;
        logic [15:0] data;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic               rf_wen;
    logic [AW-1:0]      rf_waddr;
    logic [DW-1:0]      rf_wdata;

    int tests = 0;
    int fails = 0;
    vec_t tbl[$];
    vec_t sb[$];

    rf_wport_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .gnt      (gnt),
        .rf_wen   (rf_wen),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic cmp(input string n, input vec_t e);
        chk({n, ".gnt"}, 16'(gnt), 16'(e.gnt));
        chk({n, ".wen"}, 16'(rf_wen), 16'(e.wen));
        chk({n, ".waddr"}, 16'(rf_waddr), 16'(e.addr));
        chk({n, ".wdata"}, rf_wdata, e.data);
    endtask

    function automatic vec_t v(input logic [3:0] r, input logic [3:0] g, input logic w,
                               input logic [2:0] a, input logic [15:0] d);
        vec_t t;
        t.req = r; t.gnt = g; t.wen = w; t.addr = a; t.data = d;
        return t;
    endfunction

    initial begin
        // requester 0: r5/BEEF, 1: r0/1111, 2: r2/2222, 3: r7/3333
        req_addr = {3'd7, 3'd2, 3'd0, 3'd5};
        req_data = {16'h3333, 16'h2222, 16'h1111, 16'hBEEF};
        // ptr after each row in trailing comment
        tbl.push_back(v(4'b0000, 4'b0000, 1'b0, 3'd0, 16'h0000)); // 0
        tbl.push_back(v(4'b0001, 4'b0001, 1'b1, 3'd5, 16'hBEEF)); // 1 single write
        tbl.push_back(v(4'b0000, 4'b0000, 1'b0, 3'd5, 16'hBEEF)); // 1 hold
        tbl.push_back(v(4'b1000, 4'b1000, 1'b1, 3'd7, 16'h3333)); // 0
        tbl.push_back(v(4'b0000, 4'b0000, 1'b0, 3'd7, 16'h3333)); // 0
        tbl.push_back(v(4'b1111, 4'b0001, 1'b1, 3'd5, 16'hBEEF)); // 1 round robin
        tbl.push_back(v(4'b1110, 4'b0010, W1,   3'd0, 16'h1111)); // 2
        tbl.push_back(v(4'b1100, 4'b0100, 1'b1, 3'd2, 16'h2222)); // 3
        tbl.push_back(v(4'b1000, 4'b1000, 1'b1, 3'd7, 16'h3333)); // 0
        tbl.push_back(v(4'b0000, 4'b0000, 1'b0, 3'd7, 16'h3333)); // 0
        tbl.push_back(v(4'b1001, 4'b0001, 1'b1, 3'd5, 16'hBEEF)); // 1 wrap
        tbl.push_back(v(4'b1000, 4'b1000, 1'b1, 3'd7, 16'h3333)); // 0
        tbl.push_back(v(4'b0000, 4'b0000, 1'b0, 3'd7, 16'h3333)); // 0
        tbl.push_back(v(4'b0010, 4'b0010, W1,   3'd0, 16'h1111)); // 2 r0 write
        tbl.push_back(v(4'b0000, 4'b0000, 1'b0, 3'd0, 16'h1111)); // 2
        tbl.push_back(v(4'b0101, 4'b0100, 1'b1, 3'd2, 16'h2222)); // 3 ptr decides
        tbl.push_back(v(4'b0001, 4'b0001, 1'b1, 3'd5, 16'hBEEF)); // 1
        tbl.push_back(v(4'b0000, 4'b0000, 1'b0, 3'd5, 16'hBEEF)); // 1
        tbl.push_back(v(4'b0100, 4'b0100, 1'b1, 3'd2, 16'h2222)); // 3 mask
        tbl.push_back(v(4'b0100, 4'b0000, 1'b0, 3'd2, 16'h2222)); // 3
        tbl.push_back(v(4'b0100, 4'b0100, 1'b1, 3'd2, 16'h2222)); // 3
        tbl.push_back(v(4'b0100, 4'b0000, 1'b0, 3'd2, 16'h2222)); // 3
        tbl.push_back(v(4'b0000, 4'b0000, 1'b0, 3'd2, 16'h2222)); // 3
        tbl.push_back(v(4'b0101, 4'b0001, 1'b1, 3'd5, 16'hBEEF)); // 1 alternate
        tbl.push_back(v(4'b0101, 4'b0100, 1'b1, 3'd2, 16'h2222)); // 3
        tbl.push_back(v(4'b0101, 4'b0001, 1'b1, 3'd5, 16'hBEEF)); // 1
        tbl.push_back(v(4'b0000, 4'b0000, 1'b0, 3'd5, 16'hBEEF)); // 1

        #12;
        cmp("reset", v(4'b0000, 4'b0000, 1'b0, 3'd0, 16'h0000));
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            if (sb.size() > 0) cmp($sformatf("vec%0d", i - 1), sb.pop_front());
            req = tbl[i].req;
            sb.push_back(tbl[i]);
        end
        @(negedge clk);
        cmp($sformatf("vec%0d", tbl.size() - 1), sb.pop_front());

        // reset in the middle of a grant cycle (ptr is 1 here)
        req = 4'b0010;
        @(posedge clk);
        #1;
        cmp("pre_reset", v(4'b0010, 4'b0010, W1, 3'd0, 16'h1111));
        #2;
        rst = 1'b0;
        req = 4'b0000;
        #1;
        cmp("mid_reset", v(4'b0000, 4'b0000, 1'b0, 3'd0, 16'h0000));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        cmp("post_reset", v(4'b0000, 4'b0000, 1'b0, 3'd0, 16'h0000));
        // ptr must be 0 again: 1010 picks requester 1, not 3
        req = 4'b1010;
        @(negedge clk);
        cmp("ptr_reset", v(4'b1010, 4'b0010, W1, 3'd0, 16'h1111));
        req = 4'b1000;
        @(negedge clk);
        cmp("ptr_next", v(4'b1000, 4'b1000, 1'b1, 3'd7, 16'h3333));
        req = 4'b0000;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
